// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// Imported by the loader FSM and its RAM.
package prog_loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        FINISH
    } state_t;

    localparam int unsigned PROG_DEPTH     = 256;
    localparam logic [7:0]  PROG_FILL_BYTE = 8'h00;

endpackage

// File: rtl/prog_ram.sv
// Program RAM: one write port, one registered read port.
// A same-address write and read returns the old byte.
module prog_ram
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = PROG_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Contents are never reset; only the fetch register is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into program RAM, zero-fills the tail,
// and holds the CPU in reset while doing so.
module prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    output logic [DATA_WIDTH-1:0] cpu_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  loaded_len
);

    import prog_loader_pkg::*;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LEN_WIDTH-1:0]  len_q;
    logic                  len_ok;
    logic                  accept;
    logic                  beat;
    logic                  last_beat;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;

    assign len_ok     = (len != '0) && (len <= LEN_WIDTH'(DEPTH));
    assign accept     = (state == IDLE) && start && len_ok;
    assign beat       = in_valid && in_ready;
    assign last_beat  = beat && (remaining == LEN_WIDTH'(1));
    assign wr_ptr_inc = wr_ptr + 1'b1;

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);
    assign cpu_hold = (state != IDLE);
    assign done     = (state == FINISH);

    assign we    = beat || (state == FILL);
    assign wdata = (state == FILL) ? DATA_WIDTH'(PROG_FILL_BYTE)
                                   : in_data;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                // A full-depth load wraps the pointer and skips FILL.
                if (last_beat) begin
                    state_nxt = (wr_ptr_inc != '0) ? FILL : FINISH;
                end
            end
            FILL: begin
                if (&wr_ptr) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            remaining  <= '0;
            len_q      <= '0;
            loaded_len <= '0;
            err        <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= (state == IDLE) && start && !len_ok;
            if (accept) begin
                wr_ptr    <= '0;
                remaining <= len;
                len_q     <= len;
            end
            if (beat) begin
                wr_ptr    <= wr_ptr_inc;
                remaining <= remaining - 1'b1;
            end
            if (state == FILL) begin
                wr_ptr <= wr_ptr_inc;
            end
            if (state == FINISH) begin
                loaded_len <= len_q;
            end
        end
    end

    prog_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (cpu_addr),
        .rdata (cpu_data)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table-driven readback and
// rejected-start vectors plus hand-written load sequences.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] len;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] cpu_addr;
    logic [7:0] cpu_data;
    logic       cpu_hold;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] loaded_len;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [8:0] len;
    } bad_vec_t;

    rd_vec_t  rd_t1 [5];
    rd_vec_t  rd_t3 [5];
    bad_vec_t bad_t [3];

    prog_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .loaded_len (loaded_len)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_start(input logic [8:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic stream_seq(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic rd(input string name,
                      input logic [7:0] a,
                      input logic [7:0] e);
        cpu_addr = a;
        tick();
        chk(name, {24'd0, cpu_data}, {24'd0, e});
    endtask

    initial begin
        int n;
        int rdy;

        rd_t1[0] = '{8'd0,   8'h11};
        rd_t1[1] = '{8'd1,   8'h22};
        rd_t1[2] = '{8'd2,   8'h33};
        rd_t1[3] = '{8'd3,   8'h00};
        rd_t1[4] = '{8'd255, 8'h00};
        rd_t3[0] = '{8'd0, 8'hC1};
        rd_t3[1] = '{8'd1, 8'hC2};
        rd_t3[2] = '{8'd2, 8'hC3};
        rd_t3[3] = '{8'd3, 8'hC4};
        rd_t3[4] = '{8'd4, 8'h00};
        bad_t[0] = '{9'd0};
        bad_t[1] = '{9'd257};
        bad_t[2] = '{9'd511};

        rst      = 1'b1;
        start    = 1'b0;
        len      = '0;
        in_valid = 1'b0;
        in_data  = '0;
        cpu_addr = '0;
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_loaded_len", {23'd0, loaded_len}, 0);
        chk("rst_cpu_data", {24'd0, cpu_data}, 0);
        rst = 1'b0;
        tick();

        // Test 1: len=3
        do_start(9'd3);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_hold", {31'd0, cpu_hold}, 1);
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * 8'(i + 1);
            if (in_ready) rdy++;
            tick();
        end
        in_valid = 1'b0;
        chk("t1_ready_cycles", rdy, 3);
        chk("t1_fill_ready", {31'd0, in_ready}, 0);
        wait_done("t1_done", n);
        chk("t1_fill_cycles", n, 253);
        chk("t1_hold_finish", {31'd0, cpu_hold}, 1);
        tick();
        chk("t1_done_pulse", {31'd0, done}, 0);
        chk("t1_loaded_len", {23'd0, loaded_len}, 3);
        chk("t1_hold_after", {31'd0, cpu_hold}, 0);
        chk("t1_busy_after", {31'd0, busy}, 0);
        foreach (rd_t1[i]) rd("t1_read", rd_t1[i].addr, rd_t1[i].exp);

        // Test 6: read-first on address 5
        cpu_addr = 8'd5;
        do_start(9'd8);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            tick();
            if (i == 5) chk("t6_old", {24'd0, cpu_data}, 32'h00);
            if (i == 6) chk("t6_new", {24'd0, cpu_data}, 32'hA5);
        end
        in_valid = 1'b0;
        wait_done("t6_done", n);
        tick();

        // Test 2: full-depth load
        do_start(9'd256);
        for (int i = 0; i < 256; i++) begin
            chk("t2_ready", {31'd0, in_ready}, 1);
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            if (i == 254) chk("t2_early_done", {31'd0, done}, 0);
        end
        in_valid = 1'b0;
        chk("t2_done_258", {31'd0, done}, 1);
        tick();
        chk("t2_loaded_len", {23'd0, loaded_len}, 256);
        rd("t2_rd255", 8'd255, 8'hFF);
        rd("t2_rd0", 8'd0, 8'h00);
        rd("t2_rd128", 8'd128, 8'h80);

        // Test 3: gapped stream, data held across gaps
        do_start(9'd4);
        begin
            logic [6:0] pat;
            int k;
            pat = 7'b1011001;
            k = 0;
            in_data = 8'hC1;
            for (int i = 0; i < 7; i++) begin
                in_valid = pat[i];
                in_data  = 8'hC1 + 8'(k);
                chk("t3_ready", {31'd0, in_ready}, 1);
                tick();
                if (pat[i]) k++;
            end
            in_valid = 1'b0;
        end
        chk("t3_in_fill", {31'd0, in_ready}, 0);
        wait_done("t3_done", n);
        chk("t3_fill_cycles", n, 252);
        tick();
        foreach (rd_t3[i]) rd("t3_read", rd_t3[i].addr, rd_t3[i].exp);

        // Test 4: rejected lengths, start while busy
        foreach (bad_t[i]) begin
            do_start(bad_t[i].len);
            chk("t4_err", {31'd0, err}, 1);
            chk("t4_busy", {31'd0, busy}, 0);
            chk("t4_hold", {31'd0, cpu_hold}, 0);
            tick();
            chk("t4_err_pulse", {31'd0, err}, 0);
        end
        rd("t4_ram_kept", 8'd0, 8'hC1);
        do_start(9'd2);
        start = 1'b1;
        len   = 9'd5;
        tick();
        start = 1'b0;
        chk("t4_busy_start_err", {31'd0, err}, 0);
        stream_seq(2, 8'h71);
        wait_done("t4_done", n);
        chk("t4_fill_cycles", n, 254);
        tick();
        chk("t4_loaded_len", {23'd0, loaded_len}, 2);
        rd("t4_rd1", 8'd1, 8'h72);
        rd("t4_rd2", 8'd2, 8'h00);

        // Test 5: reset mid-load
        do_start(9'd5);
        stream_seq(2, 8'h90);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_hold", {31'd0, cpu_hold}, 0);
        chk("t5_ready", {31'd0, in_ready}, 0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (done) n++;
            tick();
        end
        chk("t5_no_done", n, 0);
        do_start(9'd1);
        stream_seq(1, 8'h5A);
        wait_done("t5_done", n);
        tick();
        chk("t5_loaded_len", {23'd0, loaded_len}, 1);
        rd("t5_rd0", 8'd0, 8'h5A);
        rd("t5_rd1", 8'd1, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
